// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the SimpleRISC pipeline hazard controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int RA_REG   = 15;   // call writes the return address here

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wb;
    logic              is_ld;
  } sh_entry_t;

  localparam sh_entry_t SH_INVALID = '{valid: 1'b0, rd: '0, wb: 1'b0, is_ld: 1'b0};

  // True when a read source depends on the register written by this entry
  function automatic logic src_match(input sh_entry_t e, input logic used,
                                     input logic [REG_AW-1:0] src);
    return used & e.valid & e.wb & (e.rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mc_ex_timer.sv
// Counts the extra EX cycles of a multi-cycle op (mul/div/mod).
// Latency: busy rises the cycle after load; an op occupies EX LATENCY cycles.
// Backpressure: none; load is only raised while the timer is idle.
module mc_ex_timer #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] cnt;

  // Load on op entry, then count down to zero; reset aborts an op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW interlock, multi-cycle EX hold, branch flush.
// Latency: control outputs are combinational (0 cycles); state updates in 1 cycle.
// Backpressure: stalls PC and IF/OF while a hazard or multi-cycle op persists.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS   = pipe_ctrl_pkg::NUM_REGS,
  parameter int REG_AW     = pipe_ctrl_pkg::REG_AW,
  parameter int MC_LATENCY = 4,
  parameter int FORWARDING = 0,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              of_valid,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic              of_rs1_used,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_rs2_used,
  input  logic [REG_AW-1:0] of_rd,
  input  logic              of_wb,
  input  logic              of_is_ld,
  input  logic              of_is_mc,
  input  logic              ex_branch_taken,
  output logic              stall_pc,
  output logic              stall_if_of,
  output logic              hold_of_ex,
  output logic              bubble_of_ex,
  output logic              bubble_ex_ma,
  output logic              flush_if_of,
  output logic              flush_of_ex,
  output logic              ex_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  import pipe_ctrl_pkg::*;

  // The shadow entry's rd field is sized from the package
  if (NUM_REGS > (1 << REG_AW) || REG_AW != pipe_ctrl_pkg::REG_AW) begin : g_bad_cfg
    $error("pipe_hazard_ctrl: register file geometry does not match pipe_ctrl_pkg");
  end

  sh_entry_t sh_ex, sh_ma, sh_wb;
  logic      mc_busy;
  logic      match_ex, match_ma, match_wb;
  logic      raw, flush, issue;
  logic [CNT_W-1:0] stall_cnt;

  mc_ex_timer #(.LATENCY(MC_LATENCY)) u_mc_timer (
    .clk   (clk),
    .reset (reset),
    .load  (issue & of_is_mc),
    .busy  (mc_busy)
  );

  // RAW detection of the OF instruction against every in-flight writer
  always_comb begin
    match_ex = src_match(sh_ex, of_rs1_used, of_rs1) | src_match(sh_ex, of_rs2_used, of_rs2);
    match_ma = src_match(sh_ma, of_rs1_used, of_rs1) | src_match(sh_ma, of_rs2_used, of_rs2);
    match_wb = src_match(sh_wb, of_rs1_used, of_rs1) | src_match(sh_wb, of_rs2_used, of_rs2);
    if (FORWARDING != 0) begin
      // only a load still in EX cannot be bypassed
      raw = of_valid & match_ex & sh_ex.is_ld;
    end else begin
      // regfile is written at the end of WB, so WB still blocks
      raw = of_valid & (match_ex | match_ma | match_wb);
    end
    flush = ex_branch_taken & ~mc_busy;
    issue = of_valid & ~mc_busy & ~flush & ~raw;
  end

  // Prioritised control outputs: flush, then multi-cycle hold, then RAW stall
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_of  = 1'b0;
    hold_of_ex   = 1'b0;
    bubble_of_ex = 1'b0;
    bubble_ex_ma = 1'b0;
    flush_if_of  = 1'b0;
    flush_of_ex  = 1'b0;
    ex_busy      = 1'b0;
    if (!reset) begin
      ex_busy = mc_busy;
      if (flush) begin
        flush_if_of = 1'b1;
        flush_of_ex = 1'b1;
      end else if (mc_busy) begin
        stall_pc     = 1'b1;
        stall_if_of  = 1'b1;
        hold_of_ex   = 1'b1;
        bubble_ex_ma = 1'b1;
      end else if (raw) begin
        stall_pc     = 1'b1;
        stall_if_of  = 1'b1;
        bubble_of_ex = 1'b1;
      end
    end
  end

  // Shadow pipe: EX holds under a multi-cycle op, which sends a bubble to MA
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_ex <= SH_INVALID;
      sh_ma <= SH_INVALID;
      sh_wb <= SH_INVALID;
    end else begin
      sh_wb <= sh_ma;
      sh_ma <= mc_busy ? SH_INVALID : sh_ex;
      if (!mc_busy) begin
        if (issue) begin
          sh_ex <= '{valid: 1'b1, rd: of_rd, wb: of_wb, is_ld: of_is_ld};
        end else begin
          sh_ex <= SH_INVALID;
        end
      end
    end
  end

  // Saturating count of PC-stall cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three configurations share one stimulus stream.
// Expected outputs come from an in-flight-instruction list model, checked at negedge.
// Directed scenarios first, then randomized traffic.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, of_valid, of_rs1_used, of_rs2_used, of_wb, of_is_ld, of_is_mc, ex_branch_taken;
  logic [3:0] of_rs1, of_rs2, of_rd;

  logic [2:0]  w_stall_pc, w_stall_if_of, w_hold, w_bub_oe, w_bub_em, w_fl_io, w_fl_oe, w_busy;
  logic [31:0] sc0, sc1, sc2;

  // dut0: interlock, MC=4; dut1: forwarding, MC=4; dut2: interlock, MC=1
  pipe_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .MC_LATENCY(4), .FORWARDING(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
    .of_rs2(of_rs2), .of_rs2_used(of_rs2_used), .of_rd(of_rd), .of_wb(of_wb), .of_is_ld(of_is_ld),
    .of_is_mc(of_is_mc), .ex_branch_taken(ex_branch_taken), .stall_pc(w_stall_pc[0]),
    .stall_if_of(w_stall_if_of[0]), .hold_of_ex(w_hold[0]), .bubble_of_ex(w_bub_oe[0]),
    .bubble_ex_ma(w_bub_em[0]), .flush_if_of(w_fl_io[0]), .flush_of_ex(w_fl_oe[0]),
    .ex_busy(w_busy[0]), .stall_cycles(sc0));

  pipe_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .MC_LATENCY(4), .FORWARDING(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
    .of_rs2(of_rs2), .of_rs2_used(of_rs2_used), .of_rd(of_rd), .of_wb(of_wb), .of_is_ld(of_is_ld),
    .of_is_mc(of_is_mc), .ex_branch_taken(ex_branch_taken), .stall_pc(w_stall_pc[1]),
    .stall_if_of(w_stall_if_of[1]), .hold_of_ex(w_hold[1]), .bubble_of_ex(w_bub_oe[1]),
    .bubble_ex_ma(w_bub_em[1]), .flush_if_of(w_fl_io[1]), .flush_of_ex(w_fl_oe[1]),
    .ex_busy(w_busy[1]), .stall_cycles(sc1));

  pipe_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .MC_LATENCY(1), .FORWARDING(0), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
    .of_rs2(of_rs2), .of_rs2_used(of_rs2_used), .of_rd(of_rd), .of_wb(of_wb), .of_is_ld(of_is_ld),
    .of_is_mc(of_is_mc), .ex_branch_taken(ex_branch_taken), .stall_pc(w_stall_pc[2]),
    .stall_if_of(w_stall_if_of[2]), .hold_of_ex(w_hold[2]), .bubble_of_ex(w_bub_oe[2]),
    .bubble_ex_ma(w_bub_em[2]), .flush_if_of(w_fl_io[2]), .flush_of_ex(w_fl_oe[2]),
    .ex_busy(w_busy[2]), .stall_cycles(sc2));

  typedef struct packed {
    logic stall_pc, stall_if_of, hold_of_ex, bubble_of_ex, bubble_ex_ma, flush_if_of, flush_of_ex, ex_busy;
    logic [31:0] stall_cycles;
  } out_t;

  typedef struct { int d; out_t o; } exp_t;
  typedef struct { int d; int rd; bit wb; bit ld; int stage; } infl_t;   // stage 0=EX 1=MA 2=WB

  exp_t        expq[$];
  infl_t       infl[$];
  int          busy_left[3];
  logic [31:0] scnt[3];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int fwd_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int mc_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic out_t actual(input int d);
    out_t a;
    a.stall_pc     = w_stall_pc[d];
    a.stall_if_of  = w_stall_if_of[d];
    a.hold_of_ex   = w_hold[d];
    a.bubble_of_ex = w_bub_oe[d];
    a.bubble_ex_ma = w_bub_em[d];
    a.flush_if_of  = w_fl_io[d];
    a.flush_of_ex  = w_fl_oe[d];
    a.ex_busy      = w_busy[d];
    a.stall_cycles = (d == 0) ? sc0 : (d == 1) ? sc1 : sc2;
    return a;
  endfunction

  // Does the OF instruction depend on an unretired writer of this configuration?
  function automatic bit model_raw(input int d);
    bit hit;
    if (!of_valid) return 1'b0;
    foreach (infl[i]) begin
      if (infl[i].d == d && infl[i].wb) begin
        hit = (of_rs1_used && infl[i].rd == int'(of_rs1)) || (of_rs2_used && infl[i].rd == int'(of_rs2));
        if (hit && (fwd_of(d) == 0 || (infl[i].stage == 0 && infl[i].ld))) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Predict this cycle's outputs for all configurations, then advance the model by one clock
  task automatic step(input bit chk);
    bit    busyd[3], issue[3], spc[3];
    infl_t nq[$];
    infl_t e;
    for (int d = 0; d < 3; d++) begin
      out_t o;
      bit   busy, raw, fl;
      o = '0;
      busy = (busy_left[d] > 0);
      raw  = model_raw(d);
      fl   = ex_branch_taken && !busy;
      o.stall_cycles = scnt[d];
      if (!reset) begin
        o.ex_busy = busy;
        if (fl) begin
          o.flush_if_of = 1'b1; o.flush_of_ex = 1'b1;
        end else if (busy) begin
          o.stall_pc = 1'b1; o.stall_if_of = 1'b1; o.hold_of_ex = 1'b1; o.bubble_ex_ma = 1'b1;
        end else if (raw) begin
          o.stall_pc = 1'b1; o.stall_if_of = 1'b1; o.bubble_of_ex = 1'b1;
        end
      end
      if (chk) expq.push_back('{d: d, o: o});
      busyd[d] = busy;
      issue[d] = !reset && of_valid && !busy && !fl && !raw;
      spc[d]   = o.stall_pc;
    end
    foreach (infl[i]) begin
      e = infl[i];
      if (reset) continue;
      if (!(e.stage == 0 && busyd[e.d])) e.stage++;
      if (e.stage <= 2) nq.push_back(e);
    end
    infl = nq;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        busy_left[d] = 0;
        scnt[d] = 32'd0;
      end else begin
        if (spc[d] && scnt[d] != 32'hFFFF_FFFF) scnt[d] = scnt[d] + 32'd1;
        if (busy_left[d] > 0) busy_left[d]--;
        if (issue[d]) begin
          infl.push_back('{d: d, rd: int'(of_rd), wb: of_wb, ld: of_is_ld, stage: 0});
          if (of_is_mc) busy_left[d] = mc_of(d) - 1;
        end
      end
    end
  endtask

  // Present one cycle of OF/EX inputs (called at posedge+1)
  task automatic ins(input logic v, input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                     input logic [3:0] rs2, input logic u2, input logic wb, input logic ld,
                     input logic mc, input logic br = 1'b0, input logic rst = 1'b0);
    reset = rst; of_valid = v; of_rd = rd; of_rs1 = rs1; of_rs1_used = u1;
    of_rs2 = rs2; of_rs2_used = u2; of_wb = wb; of_is_ld = ld; of_is_mc = mc; ex_branch_taken = br;
    step(1'b1);
    @(posedge clk); #1;
  endtask

  task automatic nop();
    ins(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst();
    ins(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_cnt(input int d, input logic [31:0] want, input string name);
    out_t a;
    a = actual(d);
    vectors++;
    if (a.stall_cycles !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d stall_cycles: got %0d, expected %0d", name, d, a.stall_cycles, want);
    end
  endtask

  // Monitor: every negedge, compare all predictions queued for this cycle
  initial begin
    exp_t e;
    out_t a;
    forever begin
      @(negedge clk);
      while (expq.size() > 0) begin
        e = expq.pop_front();
        a = actual(e.d);
        vectors++;
        if (a !== e.o) begin
          miscompares++;
          $display("FAIL outputs dut%0d @%0t: got %h, expected %h", e.d, $time, a, e.o);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; of_valid = 1'b0; of_rd = '0; of_rs1 = '0; of_rs2 = '0;
    of_rs1_used = 1'b0; of_rs2_used = 1'b0; of_wb = 1'b0; of_is_ld = 1'b0; of_is_mc = 1'b0;
    ex_branch_taken = 1'b0;
    @(posedge clk); #1;
    step(1'b0);                       // first reset edge: DUT state unknown before it
    @(posedge clk); #1;

    // add r1,r2,r3 ; sub r4,r1,r5 held in OF
    rst();
    ins(1, 4'd1, 4'd2, 1, 4'd3, 1, 1, 0, 0);
    repeat (4) ins(1, 4'd4, 4'd1, 1, 4'd5, 1, 1, 0, 0);
    repeat (3) nop();
    chk_cnt(0, 32'd3, "add_sub_interlock");
    chk_cnt(1, 32'd0, "add_sub_forward");
    chk_cnt(2, 32'd3, "add_sub_mc1");

    // ld r1,4[r2] ; add r2,r1,r3 held in OF
    rst();
    ins(1, 4'd1, 4'd2, 1, 4'd0, 0, 1, 1, 0);
    repeat (4) ins(1, 4'd2, 4'd1, 1, 4'd3, 1, 1, 0, 0);
    repeat (3) nop();
    chk_cnt(0, 32'd3, "ld_use_interlock");
    chk_cnt(1, 32'd1, "ld_use_forward");

    // taken branch squashes add r1; dependent sub must not stall
    rst();
    ins(1, 4'd1, 4'd2, 1, 4'd3, 1, 1, 0, 0, 1'b1);
    ins(1, 4'd4, 4'd1, 1, 4'd5, 1, 1, 0, 0);
    repeat (3) nop();
    chk_cnt(0, 32'd0, "flush_interlock");
    chk_cnt(1, 32'd0, "flush_forward");

    // mul r6,r7,r8 ; add r9,r6,r1 held in OF
    rst();
    ins(1, 4'd6, 4'd7, 1, 4'd8, 1, 1, 0, 1);
    repeat (7) ins(1, 4'd9, 4'd6, 1, 4'd1, 1, 1, 0, 0);
    repeat (3) nop();
    chk_cnt(0, 32'd6, "mul_dep_interlock");
    chk_cnt(1, 32'd3, "mul_dep_forward");
    chk_cnt(2, 32'd3, "mul_dep_mc1");

    // reset on the 2nd busy cycle of a mul, then an independent add
    rst();
    ins(1, 4'd6, 4'd7, 1, 4'd8, 1, 1, 0, 1);
    ins(1, 4'd9, 4'd2, 1, 4'd3, 1, 1, 0, 0);
    rst();
    ins(1, 4'd10, 4'd2, 1, 4'd3, 1, 1, 0, 0);
    repeat (3) nop();
    chk_cnt(0, 32'd0, "mul_reset_interlock");
    chk_cnt(1, 32'd0, "mul_reset_forward");

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      ins($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (3) nop();

    @(negedge clk); #1;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage SimpleRISC core (fetch, IF/OF, OF/EX, EX/MA, MA/WB).
- Tracks in-flight register writers in a shadow pipe.
- Detects RAW hazards against the instruction in operand-fetch.
- Sequences multi-cycle EX ops (mul/div/mod).
- Generates PC/latch stall, bubble and branch-flush controls for top_mod.
- Keeps a saturating stall-cycle counter for the bench.

Parameters:
NUM_REGS, 16, architectural registers (r15 = ra)
REG_AW, 4, register index width
MC_LATENCY, 4, cycles a multi-cycle op occupies EX (>=1; 1 = no hold)
FORWARDING, 0, 0 = interlock on any in-flight writer; 1 = interlock only on load-use
CNT_W, 32, stall counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
of_valid  in  1  valid instruction in OF
of_rs1  in  REG_AW  first source register
of_rs1_used  in  1  rs1 is read
of_rs2  in  REG_AW  second source register (rd for st)
of_rs2_used  in  1  rs2 is read
of_rd  in  REG_AW  destination (decoder supplies 15 for call)
of_wb  in  1  instruction writes the register file
of_is_ld  in  1  instruction is ld
of_is_mc  in  1  instruction is mul/div/mod
ex_branch_taken  in  1  branch/call/ret resolved taken in EX
stall_pc  out  1  hold PC
stall_if_of  out  1  hold IF/OF latch
hold_of_ex  out  1  hold OF/EX latch (multi-cycle op still in EX)
bubble_of_ex  out  1  load NOP into OF/EX
bubble_ex_ma  out  1  load NOP into EX/MA
flush_if_of  out  1  squash IF/OF
flush_of_ex  out  1  squash OF/EX
ex_busy  out  1  multi-cycle op occupying EX
stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
  - On reset, shadow pipe is invalid, mc counter = 0, stall_cycles = 0.
  - While reset is high, all control outputs are forced to 0.
  - Reset during a multi-cycle op aborts it. ex_busy = 0 the cycle after reset deasserts.
- Shadow pipe: entries SH_EX, SH_MA, SH_WB, each {valid, rd, wb, is_ld}, advanced on every clk edge.
  - SH_WB <= SH_MA.
  - SH_MA <= ex_busy ? invalid : SH_EX.
  - SH_EX <= hold if ex_busy.
  - Otherwise SH_EX <= invalid if flush, RAW stall or !of_valid.
  - Otherwise SH_EX <= OF fields.
- Source match: a source matches an entry if its *_used is set, the entry is valid with wb = 1, and rd equals the source.
- RAW detection (combinational from OF inputs and shadow state):
  - FORWARDING=0: raw = of_valid and any source matches SH_EX, SH_MA or SH_WB. The regfile is written at end of WB, so WB counts.
  - FORWARDING=1: raw = of_valid and a source matches SH_EX with SH_EX.is_ld = 1.
- Multi-cycle timer: when an instruction with of_is_mc enters SH_EX, cnt <= MC_LATENCY-1.
  - While cnt != 0: ex_busy = 1 and cnt decrements each cycle.
  - The op leaves EX the cycle after cnt reaches 0. It occupies EX exactly MC_LATENCY cycles.
- Output priority, in order:
  1. flush = ex_branch_taken & !ex_busy. Asserts flush_if_of = flush_of_ex = 1 for exactly that cycle. All stalls are 0.
  2. ex_busy: stall_pc = stall_if_of = hold_of_ex = bubble_ex_ma = 1.
  3. raw: stall_pc = stall_if_of = bubble_of_ex = 1.
  4. Otherwise all control outputs are 0.
- ex_branch_taken is ignored while ex_busy (no branch is multi-cycle).
- stall_cycles increments when stall_pc = 1 and holds at all-ones.
- No special case for r0. Output latency is 0 cycles (combinational). State updates are single-cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - shadow entry struct {valid, rd, wb, is_ld}
  - REG_AW / NUM_REGS constants
  - RA_REG = 15
  - invalid-entry constant
- One sub-module, mc_ex_timer: load, decrement, busy. The rest is flat.

Test Plan:
- FORWARDING=0, add r1,r2,r3 then sub r4,r1,r5 -> stall_pc=1 for exactly 3 cycles (producer in EX, MA, WB), bubble_of_ex=1 each cycle; stall_cycles=3.
- FORWARDING=1, ld r1,4[r2] then add r2,r1,r3 -> 1 stall cycle. Same sequence with add producer -> 0 stall cycles.
- ex_branch_taken=1 with a dependent instruction in OF -> flush_if_of=flush_of_ex=1 for 1 cycle, stall_pc=0. Next cycle SH_EX invalid, no stall against the squashed instruction.
- MC_LATENCY=4, mul r6,r7,r8 -> ex_busy=1 and stall_pc=hold_of_ex=bubble_ex_ma=1 for 3 cycles. Then a dependent add r9,r6,r1 stalls 3 more cycles (FORWARDING=0).
- MC_LATENCY=1, mul -> ex_busy never asserts.
- reset=1 at the 2nd busy cycle of a mul -> all outputs 0 during reset. After release cnt=0, stall_cycles=0, a following independent instruction issues with no stall.
